// File: rtl/axi_lite_slave_responder_pkg.sv
// Shared constants, write-FSM encoding and small helpers for the AXI-Lite responder.
package axi_lite_slave_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WIdle = 1'b0,
    WResp = 1'b1
  } wr_state_e;

  // True when a byte address falls inside a register file of num_words 32-bit words.
  function automatic logic addr_in_range(logic [31:0] addr, int unsigned num_words);
    return addr < (num_words << 2);
  endfunction

  function automatic logic [15:0] sat_inc16(logic [15:0] v, logic inc);
    return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// Word-addressed register file: byte-enable write port, one registered read port,
// whole array cleared asynchronously on reset.
module axi_lite_regfile #(
  parameter int unsigned NumWords = 16,
  parameter int unsigned IdxW     = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [IdxW-1:0] waddr_i,
  input  logic [31:0]     wdata_i,
  input  logic [3:0]      wstrb_i,
  input  logic            re_i,
  input  logic [IdxW-1:0] raddr_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem_q [NumWords];
  logic [31:0] rdata_q;
  logic [31:0] wmask;

  assign wmask = {{8{wstrb_i[3]}}, {8{wstrb_i[2]}}, {8{wstrb_i[1]}}, {8{wstrb_i[0]}}};

  // Read samples the array before this edge's write lands, so a same-edge
  // read of the written word returns the old contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '{default: '0};
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask) | (wdata_i & wmask);
      end
      if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_slave_responder.sv
// AXI4-Lite slave backed by a small register file, with saturating
// transaction and error counters.
module axi_lite_slave_responder
  import axi_lite_slave_responder_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
  parameter int unsigned C_NUM_WORDS        = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [15:0]                     WR_COUNT,
  output logic [15:0]                     RD_COUNT,
  output logic [7:0]                      ERR_COUNT
);

  localparam int unsigned IdxW = (C_NUM_WORDS > 1) ? $clog2(C_NUM_WORDS) : 1;

  // Write side state
  wr_state_e                     state_q, state_d;
  logic                          aw_held_q, aw_held_d;
  logic                          w_held_q, w_held_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]                   wdata_q, wdata_d;
  logic [3:0]                    wstrb_q, wstrb_d;
  logic [1:0]                    bresp_q, bresp_d;

  // Read side state
  logic       rvalid_q, rvalid_d;
  logic [1:0] rresp_q, rresp_d;

  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [8:0]  err_sum;

  // Holds the READY outputs low until the first edge after reset release.
  logic rdy_en_q;

  logic bvalid, aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic commit, aw_ok, ar_ok;
  logic b_err, r_err;
  logic [31:0] rf_rdata;
  logic unused_prot;

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign bvalid        = (state_q == WResp);
  assign S_AXI_AWREADY = rdy_en_q & ~aw_held_q & ~bvalid;
  assign S_AXI_WREADY  = rdy_en_q & ~w_held_q & ~bvalid;
  assign S_AXI_ARREADY = rdy_en_q & ~rvalid_q;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign b_hs  = bvalid & S_AXI_BREADY;
  assign r_hs  = rvalid_q & S_AXI_RREADY;

  assign commit = (state_q == WIdle) & aw_held_q & w_held_q;
  assign aw_ok  = addr_in_range(32'(awaddr_q), C_NUM_WORDS);
  assign ar_ok  = addr_in_range(32'(S_AXI_ARADDR), C_NUM_WORDS);

  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = S_AXI_AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end

    case (state_q)
      WIdle: begin
        if (aw_held_q && w_held_q) begin
          state_d   = WResp;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = aw_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      WResp: begin
        if (S_AXI_BREADY) begin
          state_d = WIdle;
        end
      end
      default: state_d = WIdle;
    endcase
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = ar_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  assign b_err     = b_hs & (bresp_q == RESP_SLVERR);
  assign r_err     = r_hs & (rresp_q == RESP_SLVERR);
  assign wr_cnt_d  = sat_inc16(wr_cnt_q, b_hs);
  assign rd_cnt_d  = sat_inc16(rd_cnt_q, r_hs);
  assign err_sum   = {1'b0, err_cnt_q} + {8'd0, b_err} + {8'd0, r_err};
  assign err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= WIdle;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
      rdy_en_q  <= 1'b1;
    end
  end

  axi_lite_regfile #(
    .NumWords(C_NUM_WORDS),
    .IdxW    (IdxW)
  ) u_regfile (
    .clk_i  (ACLK),
    .rst_ni (ARESETN),
    .we_i   (commit & aw_ok),
    .waddr_i(awaddr_q[2 +: IdxW]),
    .wdata_i(wdata_q),
    .wstrb_i(wstrb_q),
    .re_i   (ar_hs & ar_ok),
    .raddr_i(S_AXI_ARADDR[2 +: IdxW]),
    .rdata_o(rf_rdata)
  );

  // Out-of-range reads return zero regardless of what the read port last held.
  assign S_AXI_RDATA  = (rresp_q == RESP_SLVERR) ? '0 : rf_rdata;
  assign S_AXI_BVALID = bvalid;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign WR_COUNT     = wr_cnt_q;
  assign RD_COUNT     = rd_cnt_q;
  assign ERR_COUNT    = err_cnt_q;

endmodule

// File: tb/tb_axi_lite_slave_responder.sv
// Directed self-checking bench for axi_lite_slave_responder.
module tb_axi_lite_slave_responder;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [7:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic [15:0] WR_COUNT, RD_COUNT;
  logic [7:0]  ERR_COUNT;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_slave_responder dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .S_AXI_AWADDR (AWADDR),
    .S_AXI_AWPROT (AWPROT),
    .S_AXI_AWVALID(AWVALID),
    .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA  (WDATA),
    .S_AXI_WSTRB  (WSTRB),
    .S_AXI_WVALID (WVALID),
    .S_AXI_WREADY (WREADY),
    .S_AXI_BRESP  (BRESP),
    .S_AXI_BVALID (BVALID),
    .S_AXI_BREADY (BREADY),
    .S_AXI_ARADDR (ARADDR),
    .S_AXI_ARPROT (ARPROT),
    .S_AXI_ARVALID(ARVALID),
    .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA  (RDATA),
    .S_AXI_RRESP  (RRESP),
    .S_AXI_RVALID (RVALID),
    .S_AXI_RREADY (RREADY),
    .WR_COUNT     (WR_COUNT),
    .RD_COUNT     (RD_COUNT),
    .ERR_COUNT    (ERR_COUNT)
  );

  // Stimulus driver: AW and W together, then collect B.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output bit ok);
    bit aw_d, w_d, a, w;
    int n;
    @(negedge ACLK);
    AWADDR = addr; AWVALID = 1'b1; WDATA = data; WSTRB = strb; WVALID = 1'b1;
    aw_d = 0; w_d = 0; n = 0;
    while (!(aw_d && w_d) && n < 50) begin
      a = AWVALID && AWREADY;
      w = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (a) begin AWVALID = 1'b0; aw_d = 1; end
      if (w) begin WVALID = 1'b0; w_d = 1; end
      @(negedge ACLK);
      n++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    BREADY = 1'b1; n = 0;
    while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
    resp = BRESP;
    ok = BVALID && aw_d && w_d;
    @(posedge ACLK); #1 BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output bit ok);
    int n;
    @(negedge ACLK);
    ARADDR = addr; ARVALID = 1'b1; n = 0;
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1 ARVALID = 1'b0;
    @(negedge ACLK);
    RREADY = 1'b1; n = 0;
    while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
    data = RDATA; resp = RRESP; ok = RVALID;
    @(posedge ACLK); #1 RREADY = 1'b0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    AWADDR = '0; AWPROT = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARPROT = '0; ARVALID = 0; RREADY = 0;
    #1;
    total++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    total++;
    if ({WR_COUNT, RD_COUNT, ERR_COUNT, BRESP, RRESP, RDATA} !== 76'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {WR_COUNT, RD_COUNT, ERR_COUNT, BRESP, RRESP, RDATA});
    end
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    total++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      bad++; $display("FAIL ready_early got=%b exp=000", {AWREADY, WREADY, ARREADY});
    end
    @(negedge ACLK);
    total++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      bad++; $display("FAIL ready_after_edge got=%b exp=111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_basic();
    logic [1:0] resp; logic [31:0] data; bit ok;
    do_write(8'h04, 32'hDEADBEEF, 4'hF, resp, ok);
    total++;
    if (!ok || resp !== 2'b00) begin bad++; $display("FAIL basic_bresp got=%b ok=%0d exp=00", resp, ok); end
    do_read(8'h04, data, resp, ok);
    total++;
    if (!ok || data !== 32'hDEADBEEF || resp !== 2'b00) begin
      bad++; $display("FAIL basic_read got=%h/%b exp=deadbeef/00", data, resp);
    end
    total++;
    if (WR_COUNT !== 16'd1 || RD_COUNT !== 16'd1) begin
      bad++; $display("FAIL basic_counts got=%0d/%0d exp=1/1", WR_COUNT, RD_COUNT);
    end
  endtask

  task automatic test_w_first();
    logic [1:0] resp; logic [31:0] data; bit ok; int extra_b;
    @(negedge ACLK);
    WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
    total++;
    if (WREADY !== 1'b1) begin bad++; $display("FAIL wfirst_wready got=%b exp=1", WREADY); end
    @(posedge ACLK); #1 WVALID = 1'b0;
    @(negedge ACLK);
    total++;
    if (WREADY !== 1'b0 || AWREADY !== 1'b1) begin
      bad++; $display("FAIL wfirst_wready_drop got=%b%b exp=01", WREADY, AWREADY);
    end
    repeat (2) @(negedge ACLK);
    AWADDR = 8'h08; AWVALID = 1'b1;
    @(posedge ACLK); #1 AWVALID = 1'b0;
    @(negedge ACLK);
    total++;
    if (BVALID !== 1'b0) begin bad++; $display("FAIL wfirst_bvalid_early got=%b exp=0", BVALID); end
    @(negedge ACLK);
    total++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      bad++; $display("FAIL wfirst_bvalid got=%b/%b exp=1/00", BVALID, BRESP);
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1 BREADY = 1'b0;
    extra_b = 0;
    repeat (4) begin @(negedge ACLK); if (BVALID) extra_b++; end
    total++;
    if (extra_b !== 0) begin bad++; $display("FAIL wfirst_single_b got=%0d exp=0", extra_b); end
    do_read(8'h08, data, resp, ok);
    total++;
    if (!ok || data !== 32'h12345678) begin
      bad++; $display("FAIL wfirst_read got=%h exp=12345678", data);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [31:0] data; bit ok;
    do_write(8'h0C, 32'hFFFFFFFF, 4'hF, resp, ok);
    do_write(8'h0C, 32'h00000000, 4'b0101, resp, ok);
    do_read(8'h0C, data, resp, ok);
    total++;
    if (!ok || data !== 32'hFF00FF00) begin bad++; $display("FAIL strobe_read got=%h exp=ff00ff00", data); end
    total++;
    if (WR_COUNT !== 16'd4 || RD_COUNT !== 16'd3) begin
      bad++; $display("FAIL strobe_counts got=%0d/%0d exp=4/3", WR_COUNT, RD_COUNT);
    end
  endtask

  task automatic test_oob();
    logic [1:0] resp; logic [31:0] data; bit ok;
    do_write(8'h40, 32'hAAAA5555, 4'hF, resp, ok);
    total++;
    if (!ok || resp !== 2'b10) begin bad++; $display("FAIL oob_bresp got=%b exp=10", resp); end
    do_read(8'h40, data, resp, ok);
    total++;
    if (!ok || data !== 32'h0 || resp !== 2'b10) begin
      bad++; $display("FAIL oob_read got=%h/%b exp=00000000/10", data, resp);
    end
    total++;
    if (ERR_COUNT !== 8'd2) begin bad++; $display("FAIL oob_errcount got=%0d exp=2", ERR_COUNT); end
    do_read(8'h00, data, resp, ok);
    total++;
    if (!ok || data !== 32'h0 || resp !== 2'b00) begin
      bad++; $display("FAIL oob_mem_unchanged got=%h/%b exp=00000000/00", data, resp);
    end
  endtask

  task automatic test_backpressure();
    @(negedge ACLK);
    AWADDR = 8'h10; WDATA = 32'h0BADF00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 8'h04; ARVALID = 1'b1;
    @(posedge ACLK); #1 AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    repeat (2) @(negedge ACLK);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({BVALID, BRESP, RVALID, RRESP, AWREADY, WREADY, ARREADY} !== 9'b1_00_1_00_000) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b exp=100100000", i,
                        {BVALID, BRESP, RVALID, RRESP, AWREADY, WREADY, ARREADY});
      end
      total++;
      if (RDATA !== 32'hDEADBEEF) begin bad++; $display("FAIL bp_rdata cyc=%0d got=%h exp=deadbeef", i, RDATA); end
      @(negedge ACLK);
    end
    BREADY = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); #1 BREADY = 1'b0; RREADY = 1'b0;
    @(negedge ACLK);
    total++;
    if ({BVALID, RVALID, AWREADY, WREADY, ARREADY} !== 5'b00111) begin
      bad++; $display("FAIL bp_release got=%b exp=00111", {BVALID, RVALID, AWREADY, WREADY, ARREADY});
    end
    total++;
    if (WR_COUNT !== 16'd6 || RD_COUNT !== 16'd6) begin
      bad++; $display("FAIL bp_counts got=%0d/%0d exp=6/6", WR_COUNT, RD_COUNT);
    end
  endtask

  task automatic test_same_edge();
    logic [1:0] resp; logic [31:0] data; bit ok;
    @(negedge ACLK);
    AWADDR = 8'h14; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(posedge ACLK); #1 AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    ARADDR = 8'h14; ARVALID = 1'b1;
    @(posedge ACLK); #1 ARVALID = 1'b0;
    @(negedge ACLK);
    total++;
    if ({RVALID, BVALID} !== 2'b11 || RDATA !== 32'h0) begin
      bad++; $display("FAIL same_edge_old got=%b%b/%h exp=11/00000000", RVALID, BVALID, RDATA);
    end
    BREADY = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); #1 BREADY = 1'b0; RREADY = 1'b0;
    do_read(8'h14, data, resp, ok);
    total++;
    if (!ok || data !== 32'hCAFEF00D) begin bad++; $display("FAIL same_edge_new got=%h exp=cafef00d", data); end
    total++;
    if (WR_COUNT !== 16'd7 || RD_COUNT !== 16'd8) begin
      bad++; $display("FAIL same_edge_counts got=%0d/%0d exp=7/8", WR_COUNT, RD_COUNT);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [31:0] data; bit ok; int b_seen;
    @(negedge ACLK);
    AWADDR = 8'h18; AWVALID = 1'b1;
    @(posedge ACLK); #1 AWVALID = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b0;
    #1;
    total++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP} !== 9'b0) begin
      bad++; $display("FAIL rstmid_ctrl got=%b exp=0", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP});
    end
    total++;
    if ({WR_COUNT, RD_COUNT, ERR_COUNT, RDATA} !== 72'h0) begin
      bad++; $display("FAIL rstmid_data got=%h exp=0", {WR_COUNT, RD_COUNT, ERR_COUNT, RDATA});
    end
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    WDATA = 32'h55AA55AA; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge ACLK); #1 WVALID = 1'b0;
    b_seen = 0;
    repeat (4) begin @(negedge ACLK); if (BVALID) b_seen++; end
    total++;
    if (b_seen !== 0) begin bad++; $display("FAIL rstmid_no_b got=%0d exp=0", b_seen); end
    do_read(8'h18, data, resp, ok);
    total++;
    if (!ok || data !== 32'h0) begin bad++; $display("FAIL rstmid_word got=%h exp=00000000", data); end
    do_read(8'h04, data, resp, ok);
    total++;
    if (!ok || data !== 32'h0) begin bad++; $display("FAIL rstmid_mem_clear got=%h exp=00000000", data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_first();
    test_strobe();
    test_oob();
    test_backpressure();
    test_same_edge();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_responder.md
AXI_LITE_SLAVE_RESPONDER -- requirements
Module: axi_lite_slave_responder

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 8, byte address width.
REQ-003 Parameter C_NUM_WORDS, default 16, register-file depth in 32-bit words (power of 2, <= 2^(C_S_AXI_ADDR_WIDTH-2)).
REQ-004 ACLK  in  1  sole clock; all logic on rising edge.
REQ-005 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-006 S_AXI_AWADDR in ADDR_WIDTH / S_AXI_AWPROT in 3 (ignored) / S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1: write address channel.
REQ-007 S_AXI_WDATA in 32 / S_AXI_WSTRB in 4 / S_AXI_WVALID in 1 / S_AXI_WREADY out 1: write data channel.
REQ-008 S_AXI_BRESP out 2 / S_AXI_BVALID out 1 / S_AXI_BREADY in 1: write response channel.
REQ-009 S_AXI_ARADDR in ADDR_WIDTH / S_AXI_ARPROT in 3 (ignored) / S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1: read address channel.
REQ-010 S_AXI_RDATA out 32 / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1: read data channel.
REQ-011 WR_COUNT out 16, RD_COUNT out 16: completed write/read transactions (B/R handshakes), saturating at 0xFFFF.
REQ-012 ERR_COUNT out 8: SLVERR responses issued, saturating at 0xFF.

Function
REQ-013 AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID; AW and W captured independently, in either order or same cycle.
REQ-014 Write FSM states W_IDLE, W_RESP; W_IDLE->W_RESP on the edge where aw_held && w_held, committing the write and setting BVALID at that edge.
REQ-015 Latency: AW and W handshaken at edge N -> commit and BVALID high after edge N+1.
REQ-016 Commit: word index = AWADDR[2+:log2(C_NUM_WORDS)]; each byte lane i written only if WSTRB[i]; AWADDR[1:0] ignored.
REQ-017 AWADDR >= 4*C_NUM_WORDS: no memory update, BRESP = 2'b10 (SLVERR); else BRESP = 2'b00.
REQ-018 W_RESP->W_IDLE on BVALID && BREADY; BVALID, BRESP held stable until then; aw_held, w_held cleared at commit.
REQ-019 ARREADY = !RVALID; on AR handshake at edge N, RDATA/RRESP registered and RVALID high after edge N (one-cycle latency).
REQ-020 Read of out-of-range address: RDATA = 32'h0, RRESP = SLVERR.
REQ-021 RVALID, RDATA, RRESP held stable until RVALID && RREADY.
REQ-022 Write commit and AR handshake on the same edge to the same word: read returns pre-write data.
REQ-023 Read and write channels fully independent; neither stalls the other.
REQ-024 WR_COUNT increments on B handshake, RD_COUNT on R handshake, ERR_COUNT on each B or R handshake carrying SLVERR (+2 if both same cycle), all saturating.

Reset
REQ-025 ARESETN low: asynchronously clear aw_held, w_held, BVALID, RVALID, AWREADY/WREADY/ARREADY low, BRESP/RRESP/RDATA = 0, counters = 0, FSM = W_IDLE.
REQ-026 Register-file contents cleared to 0 on reset.
REQ-027 Reset mid-transaction abandons it; no partial write committed after reset deassertion.
REQ-028 READY outputs rise no earlier than the first rising edge after ARESETN deasserts.

Structure
REQ-029 Shared package holds RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10 and write-FSM state encoding.
REQ-030 One sub-module axi_lite_regfile (byte-enable write port, one registered read port, async clear); rest in top.

Verification
REQ-031 Write 0xDEADBEEF to 0x04, WSTRB=4'hF, then read 0x04 -> BRESP=OKAY, RDATA=0xDEADBEEF, RRESP=OKAY, WR_COUNT=1, RD_COUNT=1.
REQ-032 W presented 3 cycles before AW to 0x08, data 0x12345678 -> WREADY drops after W handshake, single B, readback 0x12345678.
REQ-033 Word 0x0C = 0xFFFFFFFF, write 0x00000000 with WSTRB=4'b0101 -> readback 0xFF00FF00.
REQ-034 Write and read to 0x40 (C_NUM_WORDS=16) -> BRESP=SLVERR, RDATA=0, RRESP=SLVERR, ERR_COUNT=2, memory unchanged.
REQ-035 BREADY/RREADY held low 5 cycles -> BVALID/RVALID and payload stable, AWREADY/WREADY/ARREADY low until handshake.
REQ-036 ARESETN pulsed low after AW handshake, before W -> all outputs reset, target word stays 0, no B issued.
